fetch: RTL and testbench
========================

Name: fetch

Overview:
- Two-wide instruction fetch stage. Holds the architectural fetch PC and issues one 8-byte-aligned read per cycle to instruction memory.
- Presents two consecutive 32-bit instructions (PC, PC+4) to decode/dispatch. Supports PCs that are not 8-byte aligned by reusing the upper word of the previously fetched block.
- Sits between instruction memory and dispatch; the branch redirect comes from the back end.

Parameters:
- none. Width XLEN = 32 comes from the shared system-definitions package.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- take_branch_i  in  1  redirect fetch to branch_target_pc_i next cycle
- branch_target_pc_i  in  XLEN  redirect target (word aligned)
- PC_increment_i  in  2  per-slot consume mask from dispatch; bit0 = slot0 consumed, bit1 = slot1 consumed
- Imem2proc_data  in  64  data for the block at proc2Imem_addr (combinational, same cycle); [31:0] = lower word, [63:32] = upper word
- PC  out  XLEN  current fetch PC (register output)
- proc2Imem_addr  out  XLEN  8-byte-aligned memory request address (combinational)
- inst_PC_o  out  INST_PC[1:0]  two fetch slots; each slot has inst[31:0], PC[XLEN-1:0], valid

Behaviour:
- State:
  - PC register.
  - Line buffer: buf_word[31:0] = upper word of a fetched block; buf_tag = block address bits [XLEN-1:3]; buf_valid.
- Reset (async):
  - PC = 0, buf_valid = 0, buf_word = 0, buf_tag = 0.
  - Outputs are then combinational from these values: proc2Imem_addr = 0; slot0/slot1 reflect Imem2proc_data.
- Block address: blk = PC[XLEN-1:3]. hit = PC[2] & buf_valid & (buf_tag == blk).
- Aligned case (PC[2]=0):
  - addr = {blk, 3'b000}
  - slot0 = data[31:0], PC
  - slot1 = data[63:32], PC+4
  - both slots valid
- Misaligned hit (PC[2]=1, hit):
  - addr = {blk+1, 3'b000}
  - slot0 = buf_word, PC
  - slot1 = data[31:0], PC+4
  - both slots valid
- Misaligned miss (PC[2]=1, !hit, e.g. after a branch):
  - addr = {blk, 3'b000}
  - slot0 = data[63:32], PC, valid
  - slot1.valid = 0; slot1 still carries PC+4 and data[31:0]
- All outputs are combinational within the same cycle; zero latency from Imem2proc_data to inst_PC_o.
- Next PC:
  - take_branch_i=1: PC <= branch_target_pc_i. The branch has priority over PC_increment_i.
  - Otherwise PC advances by 4 per set mask bit whose slot is valid:
    - 00 -> +0
    - 01 -> +4
    - 11 -> +8 (only +4 if slot1 is invalid)
    - 10 is illegal from dispatch; it is treated as +4 if slot1 is valid.
- Buffer update:
  - Every cycle, load buf_word <= Imem2proc_data[63:32], buf_tag <= proc2Imem_addr[XLEN-1:3], buf_valid <= 1.
  - Exception: when the cycle is a hit and the next PC stays in the same block (no branch, zero advance), the buffer holds.
- PC wraps modulo 2^XLEN. No memory-ready handshake: memory data is assumed valid every cycle.
- Reset asserted mid-operation immediately returns to the reset state; in-flight slots are discarded.

Decomposition:
- Shared package (sys_defs): XLEN, INST_PC struct {inst, PC, valid}.
- One flat module; no sub-module needed. A small line_buffer register block may be factored out but is optional.

Test Plan:
- Reset, then data={4,0}, mask 00 -> slot0.inst=0, slot1.inst=4, addr=0, PC=0.
- Mask 11 with data={12,8} -> PC=8, addr=8, slots 8/12.
- Mask 01 and data={20,16} -> PC=12, addr=16, slot0=12 (buffer), slot1=16. Mask 01 again with data={20,16} -> PC=16, addr=16, slots 16/20.
- Misaligned chain, step 1: mask 01 with data={28,24} -> PC=20, addr=24, slots 20/24.
- Misaligned chain, step 2: mask 11 with data={36,32} -> PC=28, addr=32, slots 28/32.
- Branch to 0x104 (misaligned, buffer miss) with data={0x104,0x100} -> addr=0x100, slot0=0x104 valid, slot1 invalid. Mask 11 then advances PC only to 0x108.
- Stall (mask 00) at misaligned hit PC=12 for 3 cycles -> PC and slots unchanged, buffer retained (slot0 stays 12).
- Branch asserted together with mask 11 -> PC = target. Async reset pulse mid-stream -> PC=0 immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: data-path width and the per-slot record
// handed to decode/dispatch.
package fetch_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] addr_t;
    typedef logic [XLEN-1:3] blk_t;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] PC;
        logic            valid;
    } INST_PC;

    typedef enum logic [1:0] {
        FETCH_ALIGNED,
        FETCH_MIS_HIT,
        FETCH_MIS_MISS
    } fetch_case_e;

    function automatic blk_t blk_of(input addr_t a);
        return a[XLEN-1:3];
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundle of fetch-stage signals: branch redirect, dispatch consume mask,
// instruction-memory request/response and the two fetch slots.
interface fetch_if;
    import fetch_pkg::*;

    logic          take_branch_i;
    addr_t         branch_target_pc_i;
    logic [1:0]    PC_increment_i;
    logic [63:0]   Imem2proc_data;
    addr_t         PC;
    addr_t         proc2Imem_addr;
    INST_PC [1:0]  inst_PC_o;

    modport master (
        output take_branch_i, branch_target_pc_i, PC_increment_i, Imem2proc_data,
        input  PC, proc2Imem_addr, inst_PC_o
    );

    modport slave (
        input  take_branch_i, branch_target_pc_i, PC_increment_i, Imem2proc_data,
        output PC, proc2Imem_addr, inst_PC_o
    );

endinterface

// File: rtl/fetch.sv
// Two-wide fetch stage: one 8-byte block read per cycle, with a one-word line
// buffer so a PC pointing at the upper word of a block still yields two slots.
module fetch
    import fetch_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    fetch_if.slave  bus
);

    addr_t       pc_q, pc_d;
    logic [31:0] buf_word_q, buf_word_d;
    blk_t        buf_tag_q, buf_tag_d;
    logic        buf_valid_q, buf_valid_d;

    blk_t        blk;
    logic        hit;
    fetch_case_e fcase;
    addr_t       mem_addr;
    INST_PC      slot0, slot1;
    logic [1:0]  adv_words;

    // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        blk   = blk_of(pc_q);
        hit   = pc_q[2] & buf_valid_q & (buf_tag_q == blk);
        fcase = !pc_q[2] ? FETCH_ALIGNED : (hit ? FETCH_MIS_HIT : FETCH_MIS_MISS);

        mem_addr = {blk, 3'b000};
        slot0    = '{inst: bus.Imem2proc_data[31:0],  PC: pc_q,          valid: 1'b1};
        slot1    = '{inst: bus.Imem2proc_data[63:32], PC: pc_q + 32'd4,  valid: 1'b1};

        unique case (fcase)
            FETCH_ALIGNED: ;
            FETCH_MIS_HIT: begin
                // Lower word comes from the buffer, so fetch the following block.
                mem_addr   = {blk + 29'd1, 3'b000};
                slot0.inst = buf_word_q;
                slot1.inst = bus.Imem2proc_data[31:0];
            end
            FETCH_MIS_MISS: begin
                slot0.inst  = bus.Imem2proc_data[63:32];
                slot1.inst  = bus.Imem2proc_data[31:0];
                slot1.valid = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        adv_words = {1'b0, bus.PC_increment_i[0] & slot0.valid}
                  + {1'b0, bus.PC_increment_i[1] & slot1.valid};

        pc_d = bus.take_branch_i ? bus.branch_target_pc_i
                                 : pc_q + addr_t'({adv_words, 2'b00});

        buf_word_d  = bus.Imem2proc_data[63:32];
        buf_tag_d   = blk_of(mem_addr);
        buf_valid_d = 1'b1;
        // A stalled hit must keep the word it is currently presenting in slot0.
        if (hit && !bus.take_branch_i && (adv_words == 2'd0)) begin
            buf_word_d  = buf_word_q;
            buf_tag_d   = buf_tag_q;
            buf_valid_d = buf_valid_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= '0;
            buf_word_q  <= '0;
            buf_tag_q   <= '0;
            buf_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            buf_word_q  <= buf_word_d;
            buf_tag_q   <= buf_tag_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    assign bus.PC             = pc_q;
    assign bus.proc2Imem_addr = mem_addr;
    assign bus.inst_PC_o      = {slot1, slot0};

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage; memory word at address A holds the value A,
// so every expected instruction equals the address it was fetched from.
module tb_fetch;
    import fetch_pkg::*;

    typedef struct {
        string tag;
        addr_t pc;
        addr_t addr;
        logic [31:0] i0;
        logic [31:0] i1;
        logic        v1;
    } exp_t;

    logic  clk = 1'b0;
    logic  reset;
    exp_t  sb[$];
    int    checks   = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    fetch_if bus ();

    fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.Imem2proc_data = {bus.proc2Imem_addr + 32'd4, bus.proc2Imem_addr};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input string tag, input addr_t pc, input addr_t addr,
                                input logic [31:0] i0, input logic [31:0] i1, input logic v1);
        exp_t e;
        e.tag = tag; e.pc = pc; e.addr = addr; e.i0 = i0; e.i1 = i1; e.v1 = v1;
        sb.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({e.tag, ".pc"},       bus.PC,                    e.pc);
        check({e.tag, ".addr"},     bus.proc2Imem_addr,        e.addr);
        check({e.tag, ".s0.inst"},  bus.inst_PC_o[0].inst,     e.i0);
        check({e.tag, ".s0.pc"},    bus.inst_PC_o[0].PC,       e.pc);
        check({e.tag, ".s0.valid"}, {31'b0, bus.inst_PC_o[0].valid}, 32'd1);
        check({e.tag, ".s1.inst"},  bus.inst_PC_o[1].inst,     e.i1);
        check({e.tag, ".s1.pc"},    bus.inst_PC_o[1].PC,       e.pc + 32'd4);
        check({e.tag, ".s1.valid"}, {31'b0, bus.inst_PC_o[1].valid}, {31'b0, e.v1});
    endtask

    // Drive one cycle of stimulus, queue the state expected after the edge, then compare.
    task automatic step(input string tag, input logic [1:0] mask, input logic br, input addr_t tgt,
                        input addr_t pc, input addr_t addr,
                        input logic [31:0] i0, input logic [31:0] i1, input logic v1);
        bus.PC_increment_i     = mask;
        bus.take_branch_i      = br;
        bus.branch_target_pc_i = tgt;
        expect_state(tag, pc, addr, i0, i1, v1);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    initial begin
        reset                  = 1'b1;
        bus.PC_increment_i     = 2'b00;
        bus.take_branch_i      = 1'b0;
        bus.branch_target_pc_i = '0;
        #12;
        expect_state("reset", 32'h0, 32'h0, 32'h0, 32'h4, 1'b1);
        compare_front();
        @(negedge clk);
        reset = 1'b0;
        #1;
        @(posedge clk);
        #1;

        step("hold0",     2'b00, 1'b0, '0, 32'h0,  32'h0,  32'h0,  32'h4,  1'b1);
        step("adv8",      2'b11, 1'b0, '0, 32'h8,  32'h8,  32'h8,  32'hc,  1'b1);
        step("mis_hit",   2'b01, 1'b0, '0, 32'hc,  32'h10, 32'hc,  32'h10, 1'b1);
        for (int i = 0; i < 3; i++)
            step("stall",  2'b00, 1'b0, '0, 32'hc,  32'h10, 32'hc,  32'h10, 1'b1);
        step("realign",   2'b01, 1'b0, '0, 32'h10, 32'h10, 32'h10, 32'h14, 1'b1);
        step("chain1",    2'b01, 1'b0, '0, 32'h14, 32'h18, 32'h14, 32'h18, 1'b1);
        step("chain2",    2'b11, 1'b0, '0, 32'h1c, 32'h20, 32'h1c, 32'h20, 1'b1);
        step("br_miss",   2'b11, 1'b1, 32'h104, 32'h104, 32'h100, 32'h104, 32'h100, 1'b0);
        step("miss_adv",  2'b11, 1'b0, '0, 32'h108, 32'h108, 32'h108, 32'h10c, 1'b1);
        step("mask10",    2'b10, 1'b0, '0, 32'h10c, 32'h110, 32'h10c, 32'h110, 1'b1);
        step("br_top",    2'b00, 1'b1, 32'hffff_fff8,
             32'hffff_fff8, 32'hffff_fff8, 32'hffff_fff8, 32'hffff_fffc, 1'b1);
        step("wrap_hit",  2'b01, 1'b0, '0, 32'hffff_fffc, 32'h0, 32'hffff_fffc, 32'h0, 1'b1);
        step("wrap_adv",  2'b11, 1'b0, '0, 32'h4, 32'h8, 32'h4, 32'h8, 1'b1);

        bus.PC_increment_i = 2'b11;
        reset = 1'b1;
        #1;
        expect_state("async_rst", 32'h0, 32'h0, 32'h0, 32'h4, 1'b1);
        compare_front();
        @(negedge clk);
        reset = 1'b0;
        step("post_rst",  2'b01, 1'b0, '0, 32'h4, 32'h8, 32'h4, 32'h8, 1'b1);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
